// File: rtl/mini_cpu_gen2.sv
// mini_cpu_gen2: accumulator CPU that fetches one byte-serial instruction every
// four cycles (F0 -> F1 -> X0 -> X1) from an external program memory.
// Compared with the 6-bit original, it adds a configurable data width, SUB/INC
// with a carry flag, jump-on-carry, CALL/RET through a bounded return stack,
// an OUT port with a one-cycle strobe, and HALT/fault stop states.
//
// Ports
//   clk        in   1       clock, all state updates on posedge
//   reset_n    in   1       asynchronous active-low reset
//   mem_in     in   DATA_W  program memory data for mem_addr, sampled on next posedge
//   mem_addr   out  DATA_W  registered program memory address
//   out_data   out  DATA_W  value captured by the last OUT
//   out_valid  out  1       high for the single cycle after OUT executes
//   halted     out  1       core stopped (HALT or fault)
//   fault      out  1       stopped by a return-stack overflow or underflow
module mini_cpu_gen2 #(
    parameter int unsigned DATA_W      = 6,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned RESET_A     = 1,
    parameter int unsigned RESET_B     = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] mem_in,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              fault
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    typedef enum logic [1:0] {
        F0 = 2'd0,
        F1 = 2'd1,
        X0 = 2'd2,
        X1 = 2'd3
    } phase_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SWAP = 4'd2,
        OP_LDT  = 4'd3,
        OP_STT  = 4'd4,
        OP_JMP  = 4'd5,
        OP_JNZ  = 4'd6,
        OP_LDI  = 4'd7,
        OP_SUB  = 4'd8,
        OP_JC   = 4'd9,
        OP_CALL = 4'd10,
        OP_RET  = 4'd11,
        OP_OUT  = 4'd12,
        OP_HALT = 4'd13,
        OP_INC  = 4'd14
    } op_t;

    phase_t            phase;
    phase_t            phase_next;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] t;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              cy;
    logic [SP_W-1:0]   sp;

    // Array rounded up to a power of two so the pointer slice indexes it exactly;
    // entries at or beyond STACK_DEPTH are never written.
    logic [DATA_W-1:0] stack [2**IDX_W];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    op_t  op;
    logic is_imm;
    logic stack_full;
    logic stack_empty;
    logic stop;
    logic stop_fault;
    logic push;

    // Anything above 14 (including any nonzero bit above bit 3) decodes as NOP.
    always_comb begin
        op = OP_NOP;
        if (instr <= DATA_W'(14)) begin
            op = op_t'(instr[3:0]);
        end
    end

    always_comb begin
        is_imm = (op == OP_JMP) || (op == OP_JNZ) || (op == OP_LDI) ||
                 (op == OP_JC)  || (op == OP_CALL);
    end

    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign wr_idx      = sp[IDX_W-1:0];
    assign rd_idx      = wr_idx - IDX_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= F0;
        end else begin
            phase <= phase_next;
        end
    end

    // Phase sequencing plus the stop/push decisions that depend on it.
    // The phase stays put on the stopping edge and forever after.
    always_comb begin
        phase_next = phase;
        stop       = 1'b0;
        stop_fault = 1'b0;
        push       = 1'b0;
        if (!halted) begin
            unique case (phase)
                F0: phase_next = F1;
                F1: phase_next = X0;
                X0: phase_next = X1;
                X1: phase_next = F0;
            endcase
            if (phase == X0) begin
                if (op == OP_HALT) begin
                    stop = 1'b1;
                end
                if ((op == OP_RET) && stack_empty) begin
                    stop       = 1'b1;
                    stop_fault = 1'b1;
                end
            end
            if ((phase == X1) && (op == OP_CALL)) begin
                if (stack_full) begin
                    stop       = 1'b1;
                    stop_fault = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            if (stop) begin
                phase_next = phase;
            end
        end
    end

    // Stack contents need no reset: sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[wr_idx] <= pc + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a         <= DATA_W'(RESET_A);
            b         <= DATA_W'(RESET_B);
            t         <= '0;
            pc        <= '0;
            cy        <= 1'b0;
            instr     <= '0;
            sp        <= '0;
            mem_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (!halted) begin
                unique case (phase)
                    F0: begin
                        mem_addr <= pc;
                        pc       <= pc + ONE;
                    end
                    F1: begin
                        instr <= mem_in;
                    end
                    X0: begin
                        if (is_imm) begin
                            mem_addr <= pc;
                        end
                        case (op)
                            OP_ADD:  {cy, a} <= {1'b0, a} + {1'b0, b};
                            OP_SWAP: begin
                                a <= b;
                                b <= a;
                            end
                            OP_LDT:  a <= t;
                            OP_STT:  t <= a;
                            OP_SUB: begin
                                a  <= a - b;
                                cy <= (a < b);
                            end
                            OP_RET: begin
                                if (!stack_empty) begin
                                    pc <= stack[rd_idx];
                                    sp <= sp - SP_W'(1);
                                end
                            end
                            OP_OUT: begin
                                out_data  <= a;
                                out_valid <= 1'b1;
                            end
                            OP_INC:  {cy, a} <= {1'b0, a} + (DATA_W + 1)'(1);
                            default: ;
                        endcase
                    end
                    X1: begin
                        case (op)
                            OP_JMP: pc <= mem_in;
                            OP_JNZ: pc <= (a != '0) ? mem_in : pc + ONE;
                            OP_LDI: begin
                                a  <= mem_in;
                                pc <= pc + ONE;
                            end
                            OP_JC:  pc <= cy ? mem_in : pc + ONE;
                            OP_CALL: begin
                                if (push) begin
                                    sp <= sp + SP_W'(1);
                                    pc <= mem_in;
                                end
                            end
                            default: ;
                        endcase
                    end
                endcase
                if (stop) begin
                    halted <= 1'b1;
                end
                if (stop_fault) begin
                    fault <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mini_cpu_gen2.sv
module tb_mini_cpu_gen2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst6 = 1'b0;
    logic       rst8 = 1'b0;
    logic [5:0] mem_in6, addr6, out6;
    logic       ov6, h6, f6;
    logic [7:0] mem_in8, addr8, out8;
    logic       ov8, h8, f8;
    logic [5:0] mem6 [64];
    logic [7:0] mem8 [256];

    assign mem_in6 = mem6[addr6];
    assign mem_in8 = mem8[addr8];

    mini_cpu_gen2 #(.DATA_W(6), .STACK_DEPTH(2), .RESET_A(1), .RESET_B(1)) dut6 (
        .clk(clk), .reset_n(rst6), .mem_in(mem_in6), .mem_addr(addr6),
        .out_data(out6), .out_valid(ov6), .halted(h6), .fault(f6)
    );

    mini_cpu_gen2 #(.DATA_W(8), .STACK_DEPTH(4), .RESET_A(1), .RESET_B(1)) dut8 (
        .clk(clk), .reset_n(rst8), .mem_in(mem_in8), .mem_addr(addr8),
        .out_data(out8), .out_valid(ov8), .halted(h8), .fault(f8)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int sel     = 0;   // 0: 6-bit core, 1: 8-bit core

    // Instruction-level reference machine
    int m_a, m_b, m_t, m_pc, m_cy, m_mask, m_depth, m_stop;
    bit m_halt, m_fault;
    int m_stack[$];
    int seen[$];
    int q[$];

    function automatic logic [15:0] g_addr();
        return sel != 0 ? 16'(addr8) : 16'(addr6);
    endfunction
    function automatic logic [15:0] g_out();
        return sel != 0 ? 16'(out8) : 16'(out6);
    endfunction
    function automatic logic [15:0] g_ov();
        return sel != 0 ? 16'(ov8) : 16'(ov6);
    endfunction
    function automatic logic [15:0] g_h();
        return sel != 0 ? 16'(h8) : 16'(h6);
    endfunction
    function automatic logic [15:0] g_f();
        return sel != 0 ? 16'(f8) : 16'(f6);
    endfunction

    function automatic int mem_rd(input int addr);
        if (sel != 0) return int'(mem8[8'(addr)]);
        return int'(mem6[6'(addr)]);
    endfunction

    task automatic mem_wr(input int addr, input int v);
        if (sel != 0) mem8[8'(addr)] = 8'(v);
        else          mem6[6'(addr)] = 6'(v);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem_wr(i, 0);
    endtask

    task automatic load(input int base, input int vals[$]);
        for (int i = 0; i < vals.size(); i++) mem_wr(base + i, vals[i]);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input int exp);
        n_total++;
        assert (obs === 16'(exp)) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 1; m_b = 1; m_t = 0; m_pc = 0; m_cy = 0;
        m_stack.delete();
        m_halt = 0; m_fault = 0; m_stop = 0;
        m_mask  = (sel != 0) ? 255 : 63;
        m_depth = (sel != 0) ? 4 : 2;
        seen.delete();
    endtask

    // Asserts reset now (async), checks outputs immediately, releases after an edge.
    task automatic do_reset();
        if (sel != 0) rst8 = 1'b0; else rst6 = 1'b0;
        #1;
        chk("rst_addr",  g_addr(), 0);
        chk("rst_out",   g_out(),  0);
        chk("rst_valid", g_ov(),   0);
        chk("rst_halt",  g_h(),    0);
        chk("rst_fault", g_f(),    0);
        @(posedge clk); #1;
        if (sel != 0) rst8 = 1'b1; else rst6 = 1'b1;
        model_reset();
    endtask

    // Whole-instruction effect from the ISA description.
    task automatic isa_step(output int op, output int out_val);
        int pc0, inst, nxt, imm, s;
        pc0  = m_pc;
        inst = mem_rd(pc0);
        op   = (inst <= 14) ? inst : 0;
        nxt  = (pc0 + 1) & m_mask;
        imm  = mem_rd(nxt);
        out_val = 0;
        case (op)
            1:  begin s = m_a + m_b; m_cy = (s > m_mask) ? 1 : 0; m_a = s & m_mask; end
            2:  begin s = m_a; m_a = m_b; m_b = s; end
            3:  m_a = m_t;
            4:  m_t = m_a;
            5:  nxt = imm;
            6:  nxt = (m_a != 0) ? imm : ((nxt + 1) & m_mask);
            7:  begin m_a = imm; nxt = (nxt + 1) & m_mask; end
            8:  begin m_cy = (m_a < m_b) ? 1 : 0; m_a = (m_a - m_b) & m_mask; end
            9:  nxt = (m_cy != 0) ? imm : ((nxt + 1) & m_mask);
            10: begin
                if (m_stack.size() == m_depth) begin
                    m_halt = 1; m_fault = 1; m_stop = nxt;
                end else begin
                    m_stack.push_back((nxt + 1) & m_mask);
                    nxt = imm;
                end
            end
            11: begin
                if (m_stack.size() == 0) begin
                    m_halt = 1; m_fault = 1; m_stop = pc0;
                end else begin
                    nxt = m_stack.pop_back();
                end
            end
            12: out_val = m_a;
            13: begin m_halt = 1; m_stop = pc0; end
            14: begin s = m_a + 1; m_cy = (s > m_mask) ? 1 : 0; m_a = s & m_mask; end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic check_frozen(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("frz_valid",  g_ov(),   0);
            chk("frz_halted", g_h(),    1);
            chk("frz_fault",  g_f(),    int'(m_fault));
            chk("frz_addr",   g_addr(), m_stop);
        end
    endtask

    // Runs one 4-cycle instruction; entered and left 1 time unit after an edge.
    task automatic run_instr();
        int op, val, pc0;
        if (m_halt) begin
            check_frozen(4);
            return;
        end
        pc0 = m_pc;
        isa_step(op, val);
        @(posedge clk); #1;
        chk("fetch_addr", g_addr(), pc0);
        chk("run_halted", g_h(),    0);
        chk("idle_valid", g_ov(),   0);
        @(posedge clk);
        @(posedge clk); #1;
        if (op == 12) begin
            chk("out_valid", g_ov(),  1);
            chk("out_data",  g_out(), val);
            seen.push_back(int'(g_out()));
        end else begin
            chk("no_valid", g_ov(), 0);
        end
        @(posedge clk); #1;
        chk("halted", g_h(), int'(m_halt));
        chk("fault",  g_f(), int'(m_fault));
        if (m_halt) chk("stop_addr", g_addr(), m_stop);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_instr();
    endtask

    task automatic expect_seen(input string tag, input int exp[$]);
        chk({tag, "_count"}, 16'(seen.size()), exp.size());
        for (int i = 0; i < exp.size() && i < seen.size(); i++)
            chk(tag, 16'(seen[i]), exp[i]);
    endtask

    task automatic rand_prog();
        int v;
        int size;
        size = (sel != 0) ? 256 : 64;
        for (int i = 0; i < size; i++) begin
            if ($urandom_range(0, 99) < 70) begin
                v = int'($urandom_range(0, 14));
                if (v == 13 && $urandom_range(0, 3) != 0) v = 1;
                if (v == 11 && $urandom_range(0, 1) != 0) v = 14;
            end else begin
                v = int'($urandom_range(0, size - 1));
            end
            mem_wr(i, v);
        end
    endtask

    initial begin
        sel = 1; clear_mem();
        sel = 0; clear_mem();
        @(posedge clk); #1;

        // Reset mid-X0 of an ADD, then A restarts from 1
        q = '{1, 12, 1, 12}; load(0, q);
        do_reset();
        run_n(2);
        q = '{2}; expect_seen("pre_reset_out", q);
        @(posedge clk);
        @(posedge clk); #1;
        do_reset();
        run_n(2);
        q = '{2}; expect_seen("post_reset_out", q);

        // Fibonacci on the 6-bit core
        clear_mem();
        q = '{1, 2, 12, 5, 0}; load(0, q);
        do_reset();
        run_n(40);
        q = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 25}; expect_seen("fib", q);

        // Carry, JC and SUB borrow
        clear_mem();
        q = '{7, 63, 14, 9, 20}; load(0, q);
        q = '{12, 7, 3, 2, 7, 2, 8, 12, 9, 40}; load(20, q);
        q = '{13}; load(40, q);
        do_reset();
        run_n(11);
        q = '{0, 63}; expect_seen("carry", q);
        chk("carry_halt_addr", g_addr(), 40);

        // Nested CALL/RET at full depth
        clear_mem();
        q = '{10, 10, 12, 13}; load(0, q);
        q = '{10, 20, 12, 11}; load(10, q);
        q = '{14, 11}; load(20, q);
        do_reset();
        run_n(8);
        q = '{2, 2}; expect_seen("nested", q);
        chk("nested_fault", g_f(), 0);
        check_frozen(4);

        // Third nested CALL overflows
        clear_mem();
        q = '{10, 10}; load(0, q);
        q = '{10, 20}; load(10, q);
        q = '{10, 30}; load(20, q);
        do_reset();
        run_n(3);
        chk("ovf_halted", g_h(),    1);
        chk("ovf_fault",  g_f(),    1);
        chk("ovf_addr",   g_addr(), 21);
        check_frozen(8);

        // RET with an empty stack
        clear_mem();
        q = '{11}; load(0, q);
        do_reset();
        run_n(1);
        chk("udf_fault", g_f(), 1);
        check_frozen(4);

        // Plain HALT stays quiet
        clear_mem();
        q = '{13}; load(0, q);
        do_reset();
        run_n(1);
        chk("halt_fault", g_f(), 0);
        check_frozen(100);

        // Random programs on the 6-bit core
        for (int p = 0; p < 6; p++) begin
            rand_prog();
            do_reset();
            run_n(50);
        end

        // 8-bit core: wide immediate and upper-bit NOP
        sel = 1;
        clear_mem();
        q = '{7, 200, 12, 8'h8C, 7, 5, 12, 13}; load(0, q);
        do_reset();
        run_n(6);
        q = '{200, 5}; expect_seen("wide", q);

        for (int p = 0; p < 3; p++) begin
            rand_prog();
            do_reset();
            run_n(50);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
